timebase_gen: RTL and testbench

Parametrised millisecond timebase for the frontend. It produces a free-running sub-period counter, a wide period (time-tag) counter and a one-cycle `period_done` strobe. It extends the fixed-rate timer with a runtime-programmable period length, realignment to an external sync pulse from the backend, and drift/lock reporting. Event time-tagging and frame logic use it as their single shared time reference.

---
 rtl/timebase_gen.sv | 82 ++++++++
 tb/tb_timebase_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timebase_gen.sv
// timebase_gen: shared millisecond timebase for the frontend.
//   Free-running sub-period counter, wide period (time-tag) counter and a
//   one-cycle period_done strobe. Period length is runtime-programmable
//   (taken at each natural wrap) and the counters can be realigned to an
//   external sync pulse, with drift/lock reporting.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   tt_len        : requested period length in clocks (sampled at natural wrap)
//   sync_en       : enables sync realignment
//   sync_in       : single-cycle external sync pulse
//   period_load   : period value loaded on an accepted sync
//   counter       : clocks elapsed in current period (0..len-1)
//   period        : completed-period count
//   period_done   : strobe on first cycle of each new period
//   sync_err      : strobe when an accepted sync missed the boundary
//   drift         : counter value seen at the last accepted sync
//   locked        : last accepted sync landed exactly on the boundary
module timebase_gen #(
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned PERIOD_W   = 48,
  parameter int unsigned CLK_PER_TT = 90000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    tt_len,
  input  logic                sync_en,
  input  logic                sync_in,
  input  logic [PERIOD_W-1:0] period_load,
  output logic [CNT_W-1:0]    counter,
  output logic [PERIOD_W-1:0] period,
  output logic                period_done,
  output logic                sync_err,
  output logic [CNT_W-1:0]    drift,
  output logic                locked
);

  // Reset length obeys the same minimum-of-2 rule as programmed lengths.
  localparam int unsigned RST_LEN = (CLK_PER_TT < 2) ? 2 : CLK_PER_TT;

  logic [CNT_W-1:0] active_len;
  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] tt_len_clamped;
  logic             sync_acc;
  logic             at_end;

  assign len_m1         = active_len - CNT_W'(1);
  assign tt_len_clamped = (tt_len < CNT_W'(2)) ? CNT_W'(2) : tt_len;
  assign sync_acc       = sync_en & sync_in;
  assign at_end         = (counter == len_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      period      <= '0;
      period_done <= 1'b0;
      sync_err    <= 1'b0;
      drift       <= '0;
      locked      <= 1'b0;
      active_len  <= CNT_W'(RST_LEN);
    end else if (sync_acc) begin
      // Realign: active_len deliberately kept; a pending tt_len waits
      // for the next natural wrap.
      counter     <= '0;
      period      <= period_load;
      period_done <= 1'b1;
      drift       <= counter;
      locked      <= at_end;
      sync_err    <= ~at_end;
    end else if (at_end) begin
      counter     <= '0;
      period      <= period + PERIOD_W'(1);
      period_done <= 1'b1;
      sync_err    <= 1'b0;
      active_len  <= tt_len_clamped;
    end else begin
      counter     <= counter + CNT_W'(1);
      period_done <= 1'b0;
      sync_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
module tb_timebase_gen;

  localparam int CNT_W = 17;
  localparam int PERIOD_W = 48;
  localparam int CLK_PER_TT = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [CNT_W-1:0]    tt_len;
  logic                sync_en;
  logic                sync_in;
  logic [PERIOD_W-1:0] period_load;
  logic [CNT_W-1:0]    counter;
  logic [PERIOD_W-1:0] period;
  logic                period_done;
  logic                sync_err;
  logic [CNT_W-1:0]    drift;
  logic                locked;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_cnt, m_len, m_drift;
  logic [63:0] m_period;
  logic        m_done, m_err, m_locked;

  timebase_gen #(.CNT_W(CNT_W), .PERIOD_W(PERIOD_W), .CLK_PER_TT(CLK_PER_TT)) dut (
    .clk(clk), .rst(rst), .tt_len(tt_len), .sync_en(sync_en), .sync_in(sync_in),
    .period_load(period_load), .counter(counter), .period(period),
    .period_done(period_done), .sync_err(sync_err), .drift(drift), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: one clock of the timebase rules.
  task automatic model_clk();
    if (rst) begin
      m_cnt = 0; m_period = 0; m_done = 0; m_err = 0;
      m_drift = 0; m_locked = 0; m_len = CLK_PER_TT;
    end else if (sync_en && sync_in) begin
      m_locked = (m_cnt == m_len - 1);
      m_err    = !m_locked;
      m_drift  = m_cnt;
      m_cnt    = 0;
      m_period = 64'(period_load);
      m_done   = 1;
    end else if (m_cnt == m_len - 1) begin
      m_cnt    = 0;
      m_period = (m_period + 1) % (64'd1 << PERIOD_W);
      m_done   = 1;
      m_err    = 0;
      m_len    = (int'(tt_len) < 2) ? 2 : int'(tt_len);
    end else begin
      m_cnt++;
      m_done = 0;
      m_err  = 0;
    end
  endtask

  task automatic check_all();
    chk("counter", 64'(counter), 64'(m_cnt));
    chk("period", 64'(period), m_period);
    chk("period_done", 64'(period_done), 64'(m_done));
    chk("sync_err", 64'(sync_err), 64'(m_err));
    chk("drift", 64'(drift), 64'(m_drift));
    chk("locked", 64'(locked), 64'(m_locked));
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  // Steps until period_done; n is the cycle count (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_done && n < 100);
  endtask

  task automatic step_to_cnt(input int c);
    int k = 0;
    while (int'(counter) != c && k < 100) begin
      step();
      k++;
    end
    chk("reach_cnt", 64'(counter), 64'(c));
  endtask

  initial begin
    int n;
    rst = 1; tt_len = 10; sync_en = 0; sync_in = 0; period_load = '0;
    m_cnt = 0; m_len = CLK_PER_TT; m_period = 0; m_done = 0;
    m_err = 0; m_drift = 0; m_locked = 0;
    @(negedge clk);
    step(); step();
    chk("rst_counter", 64'(counter), 0);
    chk("rst_period", 64'(period), 0);
    chk("rst_done", 64'(period_done), 0);
    chk("rst_locked", 64'(locked), 0);

    // basic run, period 10
    rst = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c % 10 == 0) begin
        chk("wrap_period", 64'(period), 64'(c / 10));
        chk("wrap_done", 64'(period_done), 1);
        chk("wrap_cnt", 64'(counter), 0);
      end else begin
        chk("run_cnt", 64'(counter), 64'(c % 10));
        chk("run_done", 64'(period_done), 0);
      end
    end

    // tt_len=5 mid-period: current period keeps length 10
    step_to_cnt(3);
    tt_len = 5;
    wait_done(n); chk("len10_hold", 64'(n), 7);
    wait_done(n); chk("len5", 64'(n), 5);
    tt_len = 1;
    wait_done(n); chk("len5_tail", 64'(n), 5);
    wait_done(n); chk("len1_clamp", 64'(n), 2);
    tt_len = 0;
    wait_done(n); chk("len0_a", 64'(n), 2);
    wait_done(n); chk("len0_clamp", 64'(n), 2);
    tt_len = 10;
    wait_done(n); wait_done(n);
    chk("len10_back", 64'(n), 10);

    // sync exactly on boundary
    step_to_cnt(9);
    sync_en = 1; sync_in = 1; period_load = 48'd1000;
    step();
    sync_in = 0;
    chk("lk_cnt", 64'(counter), 0);
    chk("lk_period", 64'(period), 1000);
    chk("lk_done", 64'(period_done), 1);
    chk("lk_locked", 64'(locked), 1);
    chk("lk_err", 64'(sync_err), 0);
    chk("lk_drift", 64'(drift), 9);

    // sync mid-period
    step_to_cnt(4);
    sync_in = 1; period_load = 48'd77;
    step();
    sync_in = 0;
    chk("ms_cnt", 64'(counter), 0);
    chk("ms_period", 64'(period), 77);
    chk("ms_err", 64'(sync_err), 1);
    chk("ms_locked", 64'(locked), 0);
    chk("ms_drift", 64'(drift), 4);
    step();
    chk("ms_err_clr", 64'(sync_err), 0);
    wait_done(n); chk("ms_next_wrap", 64'(n), 9);
    chk("ms_period_inc", 64'(period), 78);

    // sync_in ignored while disabled
    sync_en = 0; sync_in = 1; period_load = 48'd5;
    step();
    chk("dis_cnt", 64'(counter), 1);
    chk("dis_period", 64'(period), 78);
    chk("dis_drift", 64'(drift), 4);
    step(); step();
    sync_in = 0;

    // sync and reset together
    sync_en = 1; sync_in = 1; rst = 1; period_load = 48'd999;
    step();
    sync_in = 0; rst = 0;
    chk("sr_cnt", 64'(counter), 0);
    chk("sr_period", 64'(period), 0);
    chk("sr_done", 64'(period_done), 0);
    chk("sr_err", 64'(sync_err), 0);

    // period rollover at 2^PERIOD_W-1
    step_to_cnt(3);
    sync_in = 1; period_load = '1;
    step();
    sync_in = 0;
    chk("ro_max", 64'(period), 64'hFFFF_FFFF_FFFF);
    wait_done(n);
    chk("ro_len", 64'(n), 10);
    chk("ro_zero", 64'(period), 0);
    chk("ro_done", 64'(period_done), 1);

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) tt_len = CNT_W'($urandom_range(0, 12));
      sync_en     = ($urandom_range(0, 3) != 0);
      sync_in     = ($urandom_range(0, 14) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      period_load = {16'($urandom), 32'($urandom)};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
